sram_rr_arbiter: RTL and testbench
==================================

Name: sram_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port synchronous SRAM among NUM_REQ requesters.
- The SRAM has a 10-bit address, 8-bit data, registered read and synchronous write.
- The block accepts at most one request per cycle using a valid/ready handshake, drives the SRAM port from registers, and routes read data back to the issuing requester with fixed latency.
- It sits between client engines and the memory.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ADDR_W, 10, SRAM address width.
- DATA_W, 8, SRAM data width.
- IDX_W, 2, requester index width; must satisfy 2**IDX_W >= NUM_REQ.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_we  in  NUM_REQ  per-requester write (1) / read (0).
- req_addr  in  NUM_REQ*ADDR_W  packed addresses; requester i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  NUM_REQ*DATA_W  packed write data; same packing.
- req_ready  out  NUM_REQ  one-hot grant; request i is accepted when req_valid[i] & req_ready[i].
- rsp_valid  out  NUM_REQ  one-hot read-data-valid pulse per requester.
- rsp_rdata  out  DATA_W  read data, shared by all requesters; qualified by rsp_valid.
- sram_we  out  1  to SRAM we.
- sram_addr  out  ADDR_W  to SRAM address.
- sram_wdata  out  DATA_W  to SRAM data_in.
- sram_rdata  in  DATA_W  from SRAM data_out.

Behaviour:
- Reset (async assert, sync-safe release):
  - sram_we=0, sram_addr=0, sram_wdata=0.
  - rsp_valid=0.
  - RR pointer = 0.
  - All pipeline valid bits cleared.
  - In-flight reads are dropped; no rsp_valid appears after reset.
- Grant logic:
  - req_ready is combinational from req_valid and the RR pointer.
  - The grant goes to the first requester with req_valid=1, searching from index ptr upward with wrap.
  - At most one bit of req_ready is set. req_ready is all-zero when no request is valid.
  - A requester never sees req_ready=1 while its req_valid=0.
- Pointer update: on an accepting edge for requester g, ptr <= (g+1) mod NUM_REQ. No accept means the pointer holds.
- Fairness: any continuously asserted request is granted within NUM_REQ cycles.
- Stage 1 (issue), at the accept edge E0:
  - sram_we <= req_we[g]; sram_addr <= addr[g]; sram_wdata <= wdata[g].
  - s1_valid <= 1; s1_rd <= ~req_we[g]; s1_id <= g.
  - With no accept: sram_we <= 0, s1_valid <= 0, sram_addr/sram_wdata hold.
- SRAM samples the port at E1. A read result is on sram_rdata after E1.
- Stage 2:
  - At E1, s2_valid <= s1_valid & s1_rd; s2_id <= s1_id.
  - rsp_valid[s2_id] = s2_valid combinationally during the cycle after E1. rsp_rdata = sram_rdata.
  - Read latency: the response is visible 2 cycles after the accepting edge.
- Throughput: one accepted request per cycle, sustained. Responses return in acceptance order.
- Writes generate no response.
- There is no response backpressure; requesters must take rsp_valid when it is presented.
- Read-during-write ordering:
  - The SRAM returns the old value when read and write hit the same cycle. This cannot occur because there is a single port.
  - A read accepted on the cycle after a write to the same address returns the new data.
- Address wrap: the address is used verbatim; no bounds checking.
- Changing req_addr/req_wdata/req_we while valid and not ready is allowed; the sampled value is taken at the accepting edge only.
- Reset asserted mid-burst: outputs go to reset values immediately (async). After release, arbitration restarts from ptr=0.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 → req_ready still one-hot (combinational), but sram_we=0, rsp_valid=0 throughout. Release → first grant goes to requester 0.
- Single write/read: req 1 writes addr 0x155 data 0xA5 at E0; req 1 reads 0x155 at E0+1 → sram_we=1 only in the cycle after E0; rsp_valid=4'b0010 with rsp_rdata=0xA5 two cycles after the read-accept edge.
- Round robin: all 4 requesters hold valid reads (addresses 0..3 preloaded with 0x10..0x13) → grant order 0,1,2,3,0,…; rsp_valid order 0,1,2,3 with data 0x10..0x13 on back-to-back cycles.
- Fairness with pointer wrap: requesters 3 and 0 valid continuously, ptr=3 → grants alternate 3,0,3,0; requester 1 raising valid is granted within 4 cycles.
- Mixed stream: write 0x3FF←0x7E, then read 0x3FF, then write 0x3FF←0x81, then read 0x3FF, back-to-back from different requesters → reads return 0x7E then 0x81. No rsp_valid for the writes.
- Reset mid-flight: accept a read, then assert rst_n=0 one cycle later → rsp_valid never asserts. sram_we=0 at once. ptr=0 after release.

Source files
------------

// File: rtl/sram_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous SRAM among NUM_REQ
// requesters; registered SRAM port, fixed two-cycle read response routing.
module sram_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int DATA_W  = 8,
  parameter int IDX_W   = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      sram_we,
  output logic [ADDR_W-1:0]         sram_addr,
  output logic [DATA_W-1:0]         sram_wdata,
  input  logic [DATA_W-1:0]         sram_rdata
);

  logic [IDX_W-1:0]   ptr_r;
  logic [IDX_W-1:0]   gnt_id_s;
  logic [IDX_W-1:0]   next_ptr_s;
  logic [IDX_W-1:0]   probe_s;
  logic [NUM_REQ-1:0] grant_s;
  logic               gnt_found_s;
  logic               hit_s;
  logic               sel_we_s;
  logic [ADDR_W-1:0]  sel_addr_s;
  logic [DATA_W-1:0]  sel_wdata_s;
  logic               s1_valid_r;
  logic               s1_rd_r;
  logic [IDX_W-1:0]   s1_id_r;
  logic               s2_valid_r;
  logic [IDX_W-1:0]   s2_id_r;

  // (base + off) mod NUM_REQ; base < NUM_REQ and off <= NUM_REQ, so one subtract suffices
  function automatic logic [IDX_W-1:0] mod_add(input logic [IDX_W-1:0] base,
                                               input logic [IDX_W:0]   off);
    logic [IDX_W+1:0] sum;
    sum = {2'b00, base} + {1'b0, off};
    if (sum >= (IDX_W+2)'(NUM_REQ)) begin
      sum = sum - (IDX_W+2)'(NUM_REQ);
    end else begin
      sum = sum;
    end
    return sum[IDX_W-1:0];
  endfunction

  // Grant search from ptr upward with wrap, then one-hot AND-OR payload mux
  always_comb begin
    grant_s     = '0;
    gnt_id_s    = '0;
    gnt_found_s = 1'b0;
    probe_s     = '0;
    hit_s       = 1'b0;
    sel_we_s    = 1'b0;
    sel_addr_s  = '0;
    sel_wdata_s = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      probe_s          = mod_add(ptr_r, (IDX_W+1)'(k));
      hit_s            = req_valid[probe_s] & ~gnt_found_s;
      grant_s[probe_s] = grant_s[probe_s] | hit_s;
      gnt_id_s         = hit_s ? probe_s : gnt_id_s;
      gnt_found_s      = gnt_found_s | hit_s;
    end
    for (int i = 0; i < NUM_REQ; i++) begin
      sel_we_s    = sel_we_s | (req_we[i] & grant_s[i]);
      sel_addr_s  = sel_addr_s | (req_addr[i*ADDR_W +: ADDR_W] & {ADDR_W{grant_s[i]}});
      sel_wdata_s = sel_wdata_s | (req_wdata[i*DATA_W +: DATA_W] & {DATA_W{grant_s[i]}});
    end
    next_ptr_s = mod_add(gnt_id_s, (IDX_W+1)'(1));
  end

  assign req_ready = grant_s;

  // Round-robin pointer advances past the accepted requester
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_r <= '0;
    end else if (gnt_found_s) begin
      ptr_r <= next_ptr_s;
    end
  end

  // Issue stage: drive the SRAM port from registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sram_we    <= 1'b0;
      sram_addr  <= '0;
      sram_wdata <= '0;
      s1_valid_r <= 1'b0;
      s1_rd_r    <= 1'b0;
      s1_id_r    <= '0;
    end else if (gnt_found_s) begin
      sram_we    <= sel_we_s;
      sram_addr  <= sel_addr_s;
      sram_wdata <= sel_wdata_s;
      s1_valid_r <= 1'b1;
      s1_rd_r    <= ~sel_we_s;
      s1_id_r    <= gnt_id_s;
    end else begin
      sram_we    <= 1'b0;
      s1_valid_r <= 1'b0;
    end
  end

  // Response stage: track which requester owns the read now on sram_rdata
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_id_r    <= '0;
    end else begin
      s2_valid_r <= s1_valid_r & s1_rd_r;
      s2_id_r    <= s1_id_r;
    end
  end

  // One-hot response pulse routed to the issuing requester
  always_comb begin
    rsp_valid          = '0;
    rsp_valid[s2_id_r] = s2_valid_r;
  end

  assign rsp_rdata = sram_rdata;

endmodule

// File: tb/tb_sram_rr_arbiter.sv
// Bench for sram_rr_arbiter: behavioural SRAM, grant vector table, and a
// scoreboard of expected read responses keyed by due cycle.
module tb_sram_rr_arbiter;

  localparam int NR = 4;
  localparam int AW = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [NR-1:0]    req_valid, req_we, req_ready, rsp_valid;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [DW-1:0]    rsp_rdata, sram_wdata, sram_rdata;
  logic             sram_we;
  logic [AW-1:0]    sram_addr;

  always #5 clk = ~clk;

  sram_rr_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW), .IDX_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .sram_we(sram_we), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata)
  );

  // Single-port SRAM: synchronous write, registered read returning old data
  logic [DW-1:0] mem [1024];
  always @(posedge clk) begin
    if (sram_we) mem[sram_addr] <= sram_wdata;
    sram_rdata <= mem[sram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct { int due; int id; logic [DW-1:0] data; } rsp_t;
  rsp_t sbq[$];
  logic [DW-1:0] ref_mem [1024];

  typedef struct { logic [NR-1:0] v; logic [NR-1:0] we; logic [NR-1:0] rdy; } vec_t;
  vec_t tbl[$];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Advance to the next falling edge and compare the response port against the scoreboard
  task automatic tick();
    @(negedge clk);
    if (sbq.size() > 0 && sbq[0].due == cyc) begin
      check("rsp_valid", 32'(rsp_valid), 32'(1 << sbq[0].id));
      check("rsp_rdata", 32'(rsp_rdata), 32'(sbq[0].data));
      void'(sbq.pop_front());
    end else begin
      check("rsp_idle", 32'(rsp_valid), 32'd0);
    end
  endtask

  task automatic set_req(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_addr[i*AW +: AW]  = a;
    req_wdata[i*DW +: DW] = d;
  endtask

  task automatic apply(input logic [NR-1:0] v, input logic [NR-1:0] we,
                       input logic [NR-1:0] rdy, input string nm);
    int g;
    logic [AW-1:0] a;
    g = -1;
    a = '0;
    req_valid = v;
    req_we    = we;
    #1;
    check({nm, "/ready"}, 32'(req_ready), 32'(rdy));
    for (int i = 0; i < NR; i++) if (rdy[i]) g = i;
    if (g >= 0) begin
      a = req_addr[g*AW +: AW];
      if (we[g]) ref_mem[a] = req_wdata[g*DW +: DW];
      else sbq.push_back('{cyc + 2, g, ref_mem[a]});
    end
    tick();
    check({nm, "/sram_we"}, 32'(sram_we), 32'((g >= 0) && we[g]));
    if (g >= 0) begin
      check({nm, "/sram_addr"}, 32'(sram_addr), 32'(a));
      if (we[g]) check({nm, "/sram_wdata"}, 32'(sram_wdata), 32'(req_wdata[g*DW +: DW]));
    end
  endtask

  initial begin
    req_valid = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    for (int i = 0; i < NR; i++) set_req(i, AW'(i), 8'h10 + 8'(i));

    // Preload via writes (grants 0..3), then reads exercising rotation, holds and wrap
    tbl.push_back('{4'b1111, 4'b1111, 4'b0001});
    tbl.push_back('{4'b1111, 4'b1111, 4'b0010});
    tbl.push_back('{4'b1111, 4'b1111, 4'b0100});
    tbl.push_back('{4'b1111, 4'b1111, 4'b1000});
    tbl.push_back('{4'b1111, 4'b0000, 4'b0001});
    tbl.push_back('{4'b1111, 4'b0000, 4'b0010});
    tbl.push_back('{4'b1111, 4'b0000, 4'b0100});
    tbl.push_back('{4'b1111, 4'b0000, 4'b1000});
    tbl.push_back('{4'b1111, 4'b0000, 4'b0001});
    tbl.push_back('{4'b0000, 4'b0000, 4'b0000});
    tbl.push_back('{4'b0001, 4'b0000, 4'b0001});
    tbl.push_back('{4'b1001, 4'b0000, 4'b1000});
    tbl.push_back('{4'b1001, 4'b0000, 4'b0001});
    tbl.push_back('{4'b1000, 4'b0000, 4'b1000});
    tbl.push_back('{4'b0110, 4'b0000, 4'b0010});
    tbl.push_back('{4'b0110, 4'b0000, 4'b0100});
    tbl.push_back('{4'b1001, 4'b0000, 4'b1000});
    tbl.push_back('{4'b1001, 4'b0000, 4'b0001});
    tbl.push_back('{4'b1001, 4'b0000, 4'b1000});
    tbl.push_back('{4'b1011, 4'b0000, 4'b0001});
    tbl.push_back('{4'b1011, 4'b0000, 4'b0010});
    tbl.push_back('{4'b1011, 4'b0000, 4'b1000});

    // Reset held with every requester asking to write
    req_valid = '1;
    req_we    = '1;
    repeat (3) begin
      tick();
      check("rst_ready", 32'(req_ready), 32'h1);
      check("rst_sram_we", 32'(sram_we), 32'd0);
    end
    rst_n = 1'b1;

    foreach (tbl[i]) apply(tbl[i].v, tbl[i].we, tbl[i].rdy, $sformatf("vec%0d", i));
    apply(4'b0000, 4'b0000, 4'b0000, "drain_a");
    apply(4'b0000, 4'b0000, 4'b0000, "drain_b");

    // Write then read-back by requester 1
    set_req(1, 10'h155, 8'hA5);
    apply(4'b0010, 4'b0010, 4'b0010, "wr155");
    apply(4'b0010, 4'b0000, 4'b0010, "rd155");
    apply(4'b0000, 4'b0000, 4'b0000, "idle1");
    apply(4'b0000, 4'b0000, 4'b0000, "idle2");

    // Back-to-back mixed stream on 0x3FF from different requesters
    set_req(0, 10'h3FF, 8'h7E);
    set_req(2, 10'h3FF, 8'h00);
    set_req(3, 10'h3FF, 8'h81);
    set_req(1, 10'h3FF, 8'h00);
    apply(4'b0001, 4'b0001, 4'b0001, "mix_w0");
    apply(4'b0100, 4'b0000, 4'b0100, "mix_r2");
    apply(4'b1000, 4'b1000, 4'b1000, "mix_w3");
    apply(4'b0010, 4'b0000, 4'b0010, "mix_r1");
    repeat (3) apply(4'b0000, 4'b0000, 4'b0000, "mix_idle");

    // Reset one cycle after a read is accepted: the read is dropped
    set_req(0, 10'h2AA, 8'h00);
    apply(4'b0001, 4'b0000, 4'b0001, "flight");
    rst_n = 1'b0;
    sbq.delete();
    req_valid = '0;
    #1;
    check("midrst_sram_we", 32'(sram_we), 32'd0);
    check("midrst_sram_addr", 32'(sram_addr), 32'd0);
    repeat (3) tick();
    rst_n = 1'b1;
    set_req(0, 10'h000, 8'h00);
    apply(4'b1111, 4'b0000, 4'b0001, "post_rst");

    for (int i = 0; i < 10 && sbq.size() > 0; i++) apply(4'b0000, 4'b0000, 4'b0000, "final");
    check("sb_empty", 32'(sbq.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
